// File: rtl/pc_pass_monitor.sv
// Test-completion detector on the fetch PC stream: flags pass when the PC steps
// from last_addr to pass_addr, or timeout after MAX_CYCLES clocks of running.
module pc_pass_monitor #(
  parameter int PC_W       = 32,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  pass_addr,
  input  logic [PC_W-1:0]  last_addr,
  input  logic             use_last,
  input  logic [PC_W-1:0]  pc_current,
  input  logic             pc_valid,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_TOUT} state_t;

  localparam logic [CYC_W-1:0] LP_MAX = CYC_W'(MAX_CYCLES);

  state_t            r_state;
  logic [CYC_W-1:0]  r_cnt;
  logic [PC_W-1:0]   r_prev_pc;
  logic [PC_W-1:0]   r_pass_addr;
  logic [PC_W-1:0]   r_last_addr;
  logic              r_use_last;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic              r_timeout;

  logic [CYC_W-1:0]  w_cnt_n;
  logic              w_hit;

  assign w_cnt_n = r_cnt + CYC_W'(1);
  assign w_hit   = pc_valid && (pc_current == r_pass_addr) &&
                   (!r_use_last || (r_prev_pc == r_last_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_prev_pc   <= '0;
      r_pass_addr <= '0;
      r_last_addr <= '0;
      r_use_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          // A hit on the limit edge still counts as a pass.
          if (w_hit) begin
            r_state <= S_PASS;
            r_cnt   <= w_cnt_n;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (w_cnt_n == LP_MAX) begin
            r_state   <= S_TOUT;
            r_cnt     <= LP_MAX;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= w_cnt_n;
            if (pc_valid) r_prev_pc <= pc_current;
          end
        end
        default: begin
          if (start) begin
            r_state     <= S_RUN;
            r_pass_addr <= pass_addr;
            r_last_addr <= last_addr;
            r_use_last  <= use_last;
            r_prev_pc   <= pc_current;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign timeout = r_timeout;
  assign cycles  = r_cnt;

endmodule

// File: tb/tb_pc_pass_monitor.sv
// Directed bench for pc_pass_monitor: pass paths, timeout, pc_valid gating,
// limit-edge tie, start-while-running and mid-run reset.
module tb_pc_pass_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pass_addr;
  logic [31:0] last_addr;
  logic        use_last;
  logic [31:0] pc_current;
  logic        pc_valid;
  logic        busy, done, pass, timeout;
  logic [15:0] cycles;

  int passed = 0;
  int total  = 0;

  pc_pass_monitor #(.PC_W(32), .CYC_W(16), .MAX_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .start(start), .pass_addr(pass_addr),
    .last_addr(last_addr), .use_last(use_last), .pc_current(pc_current),
    .pc_valid(pc_valid), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks {busy,done,pass,timeout} and cycles together.
  task automatic chk_all(input string tag, input logic [3:0] flags, input logic [15:0] cyc);
    chk({tag, ".flags"}, {28'd0, busy, done, pass, timeout}, {28'd0, flags});
    chk({tag, ".cycles"}, {16'd0, cycles}, {16'd0, cyc});
  endtask

  task automatic arm(input logic [31:0] pa, input logic [31:0] la, input logic ul,
                     input logic [31:0] pc0);
    pass_addr = pa; last_addr = la; use_last = ul;
    pc_current = pc0; pc_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pass_addr = '0; last_addr = '0; use_last = 1'b0;
    pc_current = '0; pc_valid = 1'b0;
    #12;
    chk_all("reset", 4'b0000, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("idle", 4'b0000, 16'd0);

    // 1: in-order arrival at pass address
    arm(32'h394, 32'h37C, 1'b1, 32'h36C);
    chk_all("t1.armed", 4'b1000, 16'd0);
    pc_current = 32'h370; tick();
    pc_current = 32'h374; tick();
    pc_current = 32'h37C; tick();
    chk_all("t1.e3", 4'b1000, 16'd3);
    pc_current = 32'h394; tick();
    chk_all("t1.pass", 4'b0110, 16'd4);

    // 2: wrong predecessor, then idle until timeout (restart from PASS)
    arm(32'h394, 32'h37C, 1'b1, 32'h300);
    chk_all("t2.armed", 4'b1000, 16'd0);
    pc_current = 32'h380; tick();
    pc_current = 32'h394; tick();
    chk_all("t2.nohit", 4'b1000, 16'd2);
    pc_current = 32'h398;
    for (int i = 0; i < 1997; i++) tick();
    chk_all("t2.e1999", 4'b1000, 16'd1999);
    tick();
    chk_all("t2.tout", 4'b0101, 16'd2000);
    tick();
    chk_all("t2.sticky", 4'b0101, 16'd2000);

    // 3: arrival-only mode; start while running must be ignored
    arm(32'h210, 32'h37C, 1'b0, 32'h100);
    pc_current = 32'h200; tick();
    pc_current = 32'h204; tick();
    pass_addr = 32'h999; use_last = 1'b1; start = 1'b1;
    pc_current = 32'h208; tick();
    start = 1'b0;
    chk_all("t3.ign_start", 4'b1000, 16'd3);
    pc_current = 32'h20C; tick();
    pc_current = 32'h200; tick();
    pc_current = 32'h204; tick();
    chk_all("t3.e6", 4'b1000, 16'd6);
    pc_current = 32'h210; tick();
    chk_all("t3.pass", 4'b0110, 16'd7);

    // 4: invalid samples neither hit nor update prev_pc
    arm(32'h394, 32'h37C, 1'b1, 32'h000);
    pc_valid = 1'b0; pc_current = 32'h394; tick();
    chk_all("t4.garbage", 4'b1000, 16'd1);
    pc_valid = 1'b1; pc_current = 32'h37C; tick();
    pc_valid = 1'b0; pc_current = 32'h111; tick();
    chk_all("t4.bubble", 4'b1000, 16'd3);
    pc_valid = 1'b1; pc_current = 32'h394; tick();
    chk_all("t4.pass", 4'b0110, 16'd4);

    // 5: hit on exactly the limit edge
    arm(32'h394, 32'h0, 1'b0, 32'h000);
    pc_current = 32'h010;
    for (int i = 0; i < 1999; i++) tick();
    chk_all("t5.e1999", 4'b1000, 16'd1999);
    pc_current = 32'h394; tick();
    chk_all("t5.tie", 4'b0110, 16'd2000);

    // 6: reset mid-run, then re-arm
    arm(32'h394, 32'h37C, 1'b1, 32'h000);
    pc_current = 32'h020;
    for (int i = 0; i < 50; i++) tick();
    chk_all("t6.e50", 4'b1000, 16'd50);
    rst = 1'b1;
    #1;
    chk_all("t6.rst", 4'b0000, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    arm(32'h394, 32'h37C, 1'b1, 32'h000);
    chk_all("t6.rearm", 4'b1000, 16'd0);
    tick();
    chk_all("t6.e1", 4'b1000, 16'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
